// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the five-stage core: load-use, branch-flush and
// memory-wait stall decisions, a memory-wait watchdog, and saturating stall/flush counters.
module hazard_stall_controller #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_RegDest,
    input  logic             Branch_Taken,
    input  logic             EXMEM_MemAccess,
    input  logic             Mem_Ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             Pipe_Hold,
    output logic             MEMWB_Bubble,
    output logic             Mem_Error,
    output logic [CNT_W-1:0] Stall_Cycles,
    output logic [CNT_W-1:0] Flush_Count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [15:0]      TIMEOUT_C = 16'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_next_s;
    logic [15:0]      wait_cnt_r;
    logic [15:0]      wait_next_s;
    logic [15:0]      wait_inc_s;
    logic             mem_error_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic             mem_busy_s;
    logic             load_use_s;
    logic             timeout_s;
    logic             flush_evt_s;
    logic             pc_write_s;
    logic             ifid_write_s;
    logic             ifid_flush_s;
    logic             idex_bubble_s;
    logic             pipe_hold_s;
    logic             memwb_bubble_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX_C) ? value : value + CNT_ONE_C;
    endfunction

    assign mem_busy_s = EXMEM_MemAccess & ~Mem_Ready;
    assign load_use_s = IDEX_MemRead & (IDEX_RegDest != 5'd0) &
                        ((IDEX_RegDest == IFID_Rs) | (IFID_UsesRt & (IDEX_RegDest == IFID_Rt)));
    assign wait_inc_s = (wait_cnt_r == 16'hFFFF) ? wait_cnt_r : wait_cnt_r + 16'd1;

    // Same-cycle hazard decode and next-state selection, highest priority first
    always_comb begin
        pc_write_s     = 1'b1;
        ifid_write_s   = 1'b1;
        ifid_flush_s   = 1'b0;
        idex_bubble_s  = 1'b0;
        pipe_hold_s    = 1'b0;
        memwb_bubble_s = 1'b0;
        state_next_s   = state_r;
        wait_next_s    = wait_cnt_r;
        timeout_s      = 1'b0;
        flush_evt_s    = 1'b0;
        if (Reset) begin
            pc_write_s     = 1'b0;
            ifid_write_s   = 1'b0;
            ifid_flush_s   = 1'b1;
            idex_bubble_s  = 1'b1;
            memwb_bubble_s = 1'b1;
            state_next_s   = ST_RUN;
            wait_next_s    = 16'd0;
        end else begin
            case (state_r)
                ST_RUN, ST_MEM_WAIT: begin
                    if (mem_busy_s) begin
                        pc_write_s     = 1'b0;
                        ifid_write_s   = 1'b0;
                        pipe_hold_s    = 1'b1;
                        memwb_bubble_s = 1'b1;
                        wait_next_s    = wait_inc_s;
                        if (wait_inc_s >= TIMEOUT_C) begin
                            state_next_s = ST_ERROR;
                            timeout_s    = 1'b1;
                        end else begin
                            state_next_s = ST_MEM_WAIT;
                        end
                    end else begin
                        state_next_s = ST_RUN;
                        wait_next_s  = 16'd0;
                        // A taken branch behind a load-use stall is retried next cycle
                        if (load_use_s) begin
                            pc_write_s    = 1'b0;
                            ifid_write_s  = 1'b0;
                            idex_bubble_s = 1'b1;
                        end else if (Branch_Taken) begin
                            ifid_flush_s = 1'b1;
                            flush_evt_s  = 1'b1;
                        end else begin
                            pc_write_s   = 1'b1;
                            ifid_write_s = 1'b1;
                        end
                    end
                end
                ST_ERROR: begin
                    pc_write_s     = 1'b0;
                    ifid_write_s   = 1'b0;
                    pipe_hold_s    = 1'b1;
                    memwb_bubble_s = 1'b1;
                end
                default: begin
                    pc_write_s     = 1'b0;
                    ifid_write_s   = 1'b0;
                    pipe_hold_s    = 1'b1;
                    memwb_bubble_s = 1'b1;
                    state_next_s   = ST_ERROR;
                    timeout_s      = 1'b1;
                end
            endcase
        end
    end

    // State, watchdog and saturating performance counter registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= 16'd0;
            mem_error_r <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_next_s;
            if (timeout_s) begin
                mem_error_r <= 1'b1;
            end
            if (!pc_write_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (flush_evt_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    assign PC_Write     = pc_write_s;
    assign IFID_Write   = ifid_write_s;
    assign IFID_Flush   = ifid_flush_s;
    assign IDEX_Bubble  = idex_bubble_s;
    assign Pipe_Hold    = pipe_hold_s;
    assign MEMWB_Bubble = memwb_bubble_s;
    assign Mem_Error    = mem_error_r;
    assign Stall_Cycles = stall_cnt_r;
    assign Flush_Count  = flush_cnt_r;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: two instances (default and TIMEOUT=8/CNT_W=4) share
// stimulus and are compared every cycle against a rule-level reference model.
module tb_hazard_stall_controller;

    logic       Clock;
    logic       Reset;
    logic [4:0] IFID_Rs, IFID_Rt, IDEX_RegDest;
    logic       IFID_UsesRt, IDEX_MemRead, Branch_Taken, EXMEM_MemAccess, Mem_Ready;

    logic        pcw_a, ifw_a, ifl_a, bub_a, hold_a, mwb_a, merr_a;
    logic        pcw_b, ifw_b, ifl_b, bub_b, hold_b, mwb_b, merr_b;
    logic [15:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;
    logic [5:0]  ctrl_a, ctrl_b;

    int n_checks = 0;
    int n_fail   = 0;
    int hold_seen_a;
    logic [5:0] last_ctrl_a;

    // Reference model state, index 0 = default instance, 1 = small instance
    bit m_err[2];
    bit m_merr[2];
    int m_run[2];
    int m_stall[2];
    int m_flush[2];
    int m_to[2]  = '{255, 8};
    int m_max[2] = '{65535, 15};

    typedef struct {
        logic [4:0] rs, rt;
        logic       ut, mr;
        logic [4:0] rd;
        logic       br, ma, rdy;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl[10];

    hazard_stall_controller u_dut_a (
        .Clock(Clock), .Reset(Reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_UsesRt(IFID_UsesRt), .IDEX_MemRead(IDEX_MemRead), .IDEX_RegDest(IDEX_RegDest),
        .Branch_Taken(Branch_Taken), .EXMEM_MemAccess(EXMEM_MemAccess), .Mem_Ready(Mem_Ready),
        .PC_Write(pcw_a), .IFID_Write(ifw_a), .IFID_Flush(ifl_a), .IDEX_Bubble(bub_a),
        .Pipe_Hold(hold_a), .MEMWB_Bubble(mwb_a), .Mem_Error(merr_a),
        .Stall_Cycles(stall_a), .Flush_Count(flush_a)
    );

    hazard_stall_controller #(.TIMEOUT(8), .CNT_W(4)) u_dut_b (
        .Clock(Clock), .Reset(Reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_UsesRt(IFID_UsesRt), .IDEX_MemRead(IDEX_MemRead), .IDEX_RegDest(IDEX_RegDest),
        .Branch_Taken(Branch_Taken), .EXMEM_MemAccess(EXMEM_MemAccess), .Mem_Ready(Mem_Ready),
        .PC_Write(pcw_b), .IFID_Write(ifw_b), .IFID_Flush(ifl_b), .IDEX_Bubble(bub_b),
        .Pipe_Hold(hold_b), .MEMWB_Bubble(mwb_b), .Mem_Error(merr_b),
        .Stall_Cycles(stall_b), .Flush_Count(flush_b)
    );

    assign ctrl_a = {pcw_a, ifw_a, ifl_a, bub_a, hold_a, mwb_a};
    assign ctrl_b = {pcw_b, ifw_b, ifl_b, bub_b, hold_b, mwb_b};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Hold, MEMWB_Bubble}
    function automatic logic [5:0] model_ctrl(input bit err);
        bit busy, lu;
        busy = EXMEM_MemAccess && !Mem_Ready;
        lu   = IDEX_MemRead && (IDEX_RegDest != 5'd0) &&
               ((IDEX_RegDest == IFID_Rs) || (IFID_UsesRt && (IDEX_RegDest == IFID_Rt)));
        if (Reset)        return 6'b001101;
        if (err || busy)  return 6'b000011;
        if (lu)           return 6'b000100;
        if (Branch_Taken) return 6'b111000;
        return 6'b110000;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [5:0] c;
            c = model_ctrl(m_err[i]);
            if (Reset) begin
                m_err[i] = 0; m_merr[i] = 0; m_run[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
            end else begin
                if (!c[5] && m_stall[i] < m_max[i]) m_stall[i]++;
                if (c[3] && m_flush[i] < m_max[i]) m_flush[i]++;
                if (!m_err[i]) begin
                    if (EXMEM_MemAccess && !Mem_Ready) begin
                        m_run[i]++;
                        if (m_run[i] >= m_to[i]) begin
                            m_err[i]  = 1;
                            m_merr[i] = 1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
        end
    endtask

    // Called at a falling edge with inputs already driven; checks, clocks, advances model
    task automatic apply(input string tag);
        #1;
        check($sformatf("%s ctrl_a", tag), 32'(ctrl_a), 32'(model_ctrl(m_err[0])));
        check($sformatf("%s ctrl_b", tag), 32'(ctrl_b), 32'(model_ctrl(m_err[1])));
        check($sformatf("%s merr_a", tag), 32'(merr_a), 32'(m_merr[0]));
        check($sformatf("%s merr_b", tag), 32'(merr_b), 32'(m_merr[1]));
        check($sformatf("%s stall_a", tag), 32'(stall_a), 32'(m_stall[0]));
        check($sformatf("%s stall_b", tag), 32'(stall_b), 32'(m_stall[1]));
        check($sformatf("%s flush_a", tag), 32'(flush_a), 32'(m_flush[0]));
        check($sformatf("%s flush_b", tag), 32'(flush_b), 32'(m_flush[1]));
        last_ctrl_a = ctrl_a;
        hold_seen_a += int'(hold_a);
        @(posedge Clock);
        model_step();
        @(negedge Clock);
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                          input logic mr, input logic [4:0] rd, input logic br,
                          input logic ma, input logic rdy);
        Reset = 1'b0;
        IFID_Rs = rs; IFID_Rt = rt; IFID_UsesRt = ut; IDEX_MemRead = mr;
        IDEX_RegDest = rd; Branch_Taken = br; EXMEM_MemAccess = ma; Mem_Ready = rdy;
    endtask

    task automatic do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        apply("reset");
        check("reset_ctrl", 32'(last_ctrl_a), 32'(6'b001101));
        Reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 6'b000100};
        tbl[1] = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110000};
        tbl[2] = '{5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 6'b110000};
        tbl[3] = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 6'b000100};
        tbl[4] = '{5'd2, 5'd3, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 6'b111000};
        tbl[5] = '{5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 6'b000100};
        tbl[6] = '{5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 6'b000011};
        tbl[7] = '{5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 6'b000100};
        tbl[8] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 6'b111000};
        tbl[9] = '{5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, 6'b110000};
        hold_seen_a = 0;

        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        do_reset();
        check("reset_stall_a", 32'(stall_a), 32'd0);
        check("reset_flush_a", 32'(flush_a), 32'd0);

        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].rs, tbl[i].rt, tbl[i].ut, tbl[i].mr, tbl[i].rd,
                   tbl[i].br, tbl[i].ma, tbl[i].rdy);
            apply($sformatf("vec%0d", i));
            check($sformatf("vec%0d_table", i), 32'(last_ctrl_a), 32'(tbl[i].exp));
        end

        // Four-cycle memory wait, then ready
        do_reset();
        hold_seen_a = 0;
        for (int i = 0; i < 4; i++) begin
            set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            apply("memwait");
        end
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        apply("memready");
        check("memwait_ready_ctrl", 32'(last_ctrl_a), 32'(6'b110000));
        check("memwait_hold_cycles", 32'(hold_seen_a), 32'd4);
        check("memwait_stall_a", 32'(stall_a), 32'd4);

        // Three separated branch flushes, then branch behind a load-use
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            apply("branch");
        end
        check("branch_flush_a", 32'(flush_a), 32'd3);
        check("branch_flush_b", 32'(flush_b), 32'd3);
        set_in(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        apply("br_lu");
        check("br_lu_noflush", 32'(last_ctrl_a), 32'(6'b000100));
        set_in(5'd6, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        apply("br_retry");
        check("br_retry_flush", 32'(last_ctrl_a), 32'(6'b111000));
        check("br_retry_count", 32'(flush_a), 32'd4);

        // Watchdog on the TIMEOUT=8 instance
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            apply("wdog");
        end
        check("wdog_merr_b", 32'(merr_b), 32'd1);
        check("wdog_merr_a", 32'(merr_a), 32'd0);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        apply("wdog_ready");
        check("wdog_sticky_b", 32'(merr_b), 32'd1);
        do_reset();
        check("wdog_clr_merr_b", 32'(merr_b), 32'd0);
        check("wdog_clr_stall_b", 32'(stall_b), 32'd0);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("wdog_idle_pcw_b", 32'(pcw_b), 32'd1);
        apply("wdog_idle");

        // Stall counter saturation on the 4-bit instance
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
            apply("sat");
        end
        check("sat_stall_b", 32'(stall_b), 32'd15);
        check("sat_stall_a", 32'(stall_a), 32'd20);

        // Randomized traffic with alternating fast/slow memory windows
        for (int c = 0; c < 3000; c++) begin
            int slow;
            slow = ((c / 100) % 2 == 1) ? 10 : 3;
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, slow - 1) == 0));
            Reset = ($urandom_range(0, 127) == 0);
            apply("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
